// File: rtl/gs_cpld.sv
// rtl/gs_cpld.sv - GS sound board glue CPLD: clock mux, warm reset, memory decode, FPGA config port
module gs_cpld (
    input  logic       clkin,
    input  logic       coldres,
    input  logic       clk24in,
    input  logic       clk20in,
    input  logic       clksel0,
    input  logic       clksel1,
    output logic       clkout,
    output wire        warmres_n,
    output logic       config_n,
    input  logic       status_n,
    input  logic       conf_done,
    input  logic       init_done,
    output logic       cs,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a6,
    input  logic       a7,
    input  logic       a10,
    input  logic       a11,
    input  logic       a12,
    input  logic       a13,
    input  logic       a14,
    input  logic       a15,
    inout  wire  [7:0] d,
    output logic       memoe_n,
    output logic       memwe_n,
    output logic       romcs_n,
    output logic       mema14,
    output logic       mema15,
    output logic       mema19,
    inout  wire  [7:0] rd,
    output logic       ra6,
    output logic       ra7,
    output logic       ra10,
    output logic       ra11,
    output logic       ra12,
    output logic       ra13
);

    typedef enum logic [1:0] {RUN, GAP1, GAP2} mux_state_t;

    mux_state_t  mux_state;
    logic [1:0]  sel_meta, sel_sync, sel_cur;
    logic        gate_en;
    logic        div20, div24;
    logic        src_clk;
    logic [3:0]  warm_cnt;
    logic        warm_drive;
    logic        coldflag;
    logic        io_wr;
    logic        io_rd;
    logic        d_oe;
    logic [7:0]  d_out;
    logic        unused_dbits;

    // Dividers run in the oscillator domains; their phase is irrelevant, reset only avoids X.
    always_ff @(posedge clk20in) begin
        if (coldres) div20 <= 1'b0;
        else         div20 <= ~div20;
    end

    always_ff @(posedge clk24in) begin
        if (coldres) div24 <= 1'b0;
        else         div24 <= ~div24;
    end

    // Selection change: gate off, hold clkout low two clkin cycles, then switch and reopen.
    always_ff @(posedge clkin) begin
        if (coldres) begin
            sel_meta  <= 2'b00;
            sel_sync  <= 2'b00;
            sel_cur   <= 2'b00;
            gate_en   <= 1'b1;
            mux_state <= RUN;
        end else begin
            sel_meta <= {clksel1, clksel0};
            sel_sync <= sel_meta;
            case (mux_state)
                RUN: begin
                    if (sel_sync != sel_cur) begin
                        gate_en   <= 1'b0;
                        mux_state <= GAP1;
                    end
                end
                GAP1: mux_state <= GAP2;
                GAP2: begin
                    sel_cur   <= sel_sync;
                    gate_en   <= 1'b1;
                    mux_state <= RUN;
                end
                default: mux_state <= RUN;
            endcase
        end
    end

    always_comb begin
        src_clk = 1'b0;
        case (sel_cur)
            2'b00: src_clk = clk20in;
            2'b01: src_clk = clk24in;
            2'b10: src_clk = div20;
            2'b11: src_clk = div24;
            default: src_clk = 1'b0;
        endcase
    end

    assign clkout = gate_en & src_clk;

    always_ff @(posedge clkin) begin
        if (coldres) begin
            warm_drive <= 1'b1;
            warm_cnt   <= 4'd0;
        end else if (warm_drive) begin
            warm_cnt <= warm_cnt + 4'd1;
            if (warm_cnt == 4'd15) warm_drive <= 1'b0;
        end
    end

    assign warmres_n = warm_drive ? 1'b0 : 1'bz;

    assign io_wr = ~iorq_n & ~wr_n & a7 & ~a6;
    assign io_rd = ~iorq_n & ~rd_n;

    // coldflag is sticky: only a cold reset clears it.
    always_ff @(posedge clkin) begin
        if (coldres) begin
            config_n <= 1'b0;
            coldflag <= 1'b0;
        end else if (io_wr) begin
            config_n <= d[0];
            if (d[7]) coldflag <= 1'b1;
        end
    end

    assign unused_dbits = ^d[6:1];

    assign ra6     = a6;
    assign ra7     = a7;
    assign ra10    = a10;
    assign ra11    = a11;
    assign ra12    = a12;
    assign ra13    = a13;
    assign mema14  = a14;
    assign mema15  = a15;
    assign mema19  = a15 | a14;
    assign cs      = a7 & a6;
    assign romcs_n = ~(~mreq_n & ~a15 & ~a14);
    assign memoe_n = mreq_n | rd_n;
    assign memwe_n = mreq_n | wr_n | ~(a15 | a14);

    assign rd = ~memwe_n ? d : 8'hzz;

    always_comb begin
        d_oe  = 1'b0;
        d_out = 8'h00;
        if (~memoe_n & romcs_n) begin
            d_oe  = 1'b1;
            d_out = rd;
        end else if (io_rd & a7 & ~a6) begin
            d_oe  = 1'b1;
            d_out = {status_n, 5'b00000, init_done, conf_done};
        end else if (io_rd & ~a7 & a6) begin
            d_oe  = 1'b1;
            d_out = {coldflag, 7'b0000000};
        end
    end

    assign d = d_oe ? d_out : 8'hzz;

endmodule

// File: tb/tb_gs_cpld.sv
// tb/tb_gs_cpld.sv - scoreboard bench for gs_cpld
module tb_gs_cpld;

    logic clkin = 1'b0, clk20in = 1'b0, clk24in = 1'b0;
    logic coldres;
    logic [1:0] clksel;
    logic status_n, conf_done, init_done;
    logic mreq_n, iorq_n, rd_n, wr_n;
    logic [15:0] addr;
    logic [7:0] tb_d, ram_q;
    logic tb_d_oe;
    logic clkout, config_n, cs, memoe_n, memwe_n, romcs_n;
    logic mema14, mema15, mema19, ra6, ra7, ra10, ra11, ra12, ra13;
    wire warmres_n;
    wire [7:0] d, rd;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    always #5 clkin = ~clkin;
    always #25 clk20in = ~clk20in;
    always #21 clk24in = ~clk24in;

    pullup (warmres_n);
    pullup (d);
    pullup (rd);

    assign d  = tb_d_oe ? tb_d : 8'hzz;
    assign rd = ~memoe_n ? ram_q : 8'hzz;

    // FPGA model: status_n follows nCONFIG after about 1 us.
    always @(config_n) status_n <= #1000 config_n;

    gs_cpld dut (
        .clkin(clkin), .coldres(coldres), .clk24in(clk24in), .clk20in(clk20in),
        .clksel0(clksel[0]), .clksel1(clksel[1]), .clkout(clkout),
        .warmres_n(warmres_n), .config_n(config_n), .status_n(status_n),
        .conf_done(conf_done), .init_done(init_done), .cs(cs),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .a6(addr[6]), .a7(addr[7]), .a10(addr[10]), .a11(addr[11]),
        .a12(addr[12]), .a13(addr[13]), .a14(addr[14]), .a15(addr[15]),
        .d(d), .memoe_n(memoe_n), .memwe_n(memwe_n), .romcs_n(romcs_n),
        .mema14(mema14), .mema15(mema15), .mema19(mema19), .rd(rd),
        .ra6(ra6), .ra7(ra7), .ra10(ra10), .ra11(ra11), .ra12(ra12), .ra13(ra13)
    );

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: got %h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: got %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] v);
        @(negedge clkin);
        addr = {8'h00, a};
        tb_d = v; tb_d_oe = 1'b1;
        iorq_n = 1'b0; wr_n = 1'b0;
        @(negedge clkin);
        iorq_n = 1'b1; wr_n = 1'b1; tb_d_oe = 1'b0;
    endtask

    task automatic io_read(input string tag, input logic [7:0] a, input logic [7:0] e);
        @(negedge clkin);
        addr = {8'h00, a};
        push(e);
        iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        chk(tag, d);
        #1;
        iorq_n = 1'b1; rd_n = 1'b1;
    endtask

    initial begin
        logic [1:0] cur_sel, new_sel;
        int highs, edges;
        logic prev;

        coldres = 1'b1; clksel = 2'b00; status_n = 1'b0;
        conf_done = 1'b1; init_done = 1'b1;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = 16'h0000; tb_d = 8'h00; tb_d_oe = 1'b0; ram_q = 8'h00;

        repeat (5) @(posedge clkin);
        #1;
        push(8'h00); chk("rst_warmres", {7'b0, warmres_n});
        push(8'h00); chk("rst_config_n", {7'b0, config_n});
        push(8'h01); chk("rst_clkout_known", {7'b0, (clkout === 1'b0) || (clkout === 1'b1)});
        @(negedge clkin);
        coldres = 1'b0;
        repeat (15) @(posedge clkin);
        #1;
        push(8'h00); chk("warm_15", {7'b0, warmres_n});
        @(posedge clkin);
        #1;
        push(8'h01); chk("warm_16_released", {7'b0, warmres_n});

        io_read("rd80_after_reset", 8'h80, 8'h03);
        io_write(8'h80, 8'h01);
        push(8'h01); chk("config_n_set", {7'b0, config_n});
        #1100;
        io_read("rd80_status_hi", 8'h80, 8'h83);
        io_write(8'h80, 8'h00);
        push(8'h00); chk("config_n_clr", {7'b0, config_n});
        #1100;
        io_read("rd80_status_lo", 8'h80, 8'h03);

        io_read("rd40_reset", 8'h40, 8'h00);
        io_write(8'h80, 8'h81);
        io_read("rd40_set", 8'h40, 8'h80);
        io_write(8'h80, 8'h01);
        io_read("rd40_sticky", 8'h40, 8'h80);

        #1100;
        conf_done = 1'b0;
        io_read("rd80_confdone0", 8'h80, 8'h82);
        conf_done = 1'b1;
        io_read("rd80_confdone1", 8'h80, 8'h83);
        io_read("rd00_undriven", 8'h00, 8'hFF);
        io_read("rdC0_undriven", 8'hC0, 8'hFF);

        foreach (addr[i]) if (i < 4) begin
            addr = 16'(i * 16'h0040);
            #1;
            push((i == 3) ? 8'h01 : 8'h00);
            chk("cs_decode", {7'b0, cs});
        end

        addr = 16'h4567; tb_d = 8'hA5; tb_d_oe = 1'b1; mreq_n = 1'b0; wr_n = 1'b0;
        #1;
        push(8'h00); chk("memwr_we", {7'b0, memwe_n});
        push(8'h01); chk("memwr_romcs", {7'b0, romcs_n});
        push(8'hA5); chk("memwr_rd", rd);
        push(8'h05); chk("memwr_upper", {5'b0, mema19, mema15, mema14});
        push({2'b0, addr[13:10], addr[7:6]});
        chk("memwr_ra", {2'b0, ra13, ra12, ra11, ra10, ra7, ra6});
        mreq_n = 1'b1; wr_n = 1'b1; tb_d_oe = 1'b0;
        #1;

        addr = 16'h4321; ram_q = 8'h5A; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
        push(8'h00); chk("memrd_oe", {7'b0, memoe_n});
        push(8'h5A); chk("memrd_d", d);
        mreq_n = 1'b1; rd_n = 1'b1;
        #1;

        addr = 16'h3210; tb_d = 8'h99; tb_d_oe = 1'b1; mreq_n = 1'b0; wr_n = 1'b0;
        #1;
        push(8'h00); chk("romwr_romcs", {7'b0, romcs_n});
        push(8'h01); chk("romwr_we_blocked", {7'b0, memwe_n});
        push(8'hFF); chk("romwr_rd_undriven", rd);
        mreq_n = 1'b1; wr_n = 1'b1; tb_d_oe = 1'b0;
        #1;

        addr = 16'h0123; ram_q = 8'h3C; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
        push(8'h00); chk("romrd_romcs", {7'b0, romcs_n});
        push(8'hFF); chk("romrd_d_undriven", d);
        mreq_n = 1'b1; rd_n = 1'b1;

        // Cold reset arriving together with a write wins.
        @(negedge clkin);
        addr = 16'h0080; tb_d = 8'h81; tb_d_oe = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
        coldres = 1'b1;
        @(negedge clkin);
        iorq_n = 1'b1; wr_n = 1'b1; tb_d_oe = 1'b0;
        push(8'h00); chk("reset_over_write_cfg", {7'b0, config_n});
        coldres = 1'b0;
        io_read("reset_over_write_flag", 8'h40, 8'h00);

        cur_sel = 2'b00;
        for (int k = 0; k < 8; k++) begin
            edges = 0;
            for (int t = 0; t < 5000 && edges < 10; t++) begin
                prev = clkout;
                #1;
                if (clkout !== prev) edges++;
            end
            push(8'd10); chk("clkout_toggles", 8'(edges));
            new_sel = cur_sel ^ 2'($urandom_range(1, 3));
            @(negedge clkin);
            clksel = new_sel;
            repeat (3) @(posedge clkin);
            highs = 0;
            for (int t = 0; t < 18; t++) begin
                #1;
                if (clkout !== 1'b0) highs++;
            end
            push(8'd0); chk("switch_gap_low", 8'(highs));
            cur_sel = new_sel;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
